mmio_clint: RTL and testbench

Memory-mapped core-local interruptor serving the CPU's data-memory port as a responder. It sits beside data memory on the same address/write-data/write-enable bus and answers accesses in its address window. It provides a free-running 64-bit `mtime` with a programmable prescaler, a 64-bit `mtimecmp`, a software-interrupt bit, and the resulting `timer_irq` and `sw_irq` interrupt lines. Reads are combinational so the single-cycle CPU sees data in the same cycle; writes commit on the clock edge.

---
 rtl/clint_pkg.sv | 37 +++
 rtl/clint_prescaler.sv | 30 +++
 rtl/mmio_clint.sv | 89 ++++++++
 tb/tb_mmio_clint.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Register offsets and reset constants for the core-local interruptor.
// Shared by the prescaler and the memory-mapped top.
// No flow control: all accesses complete in one cycle.
package clint_pkg;

    localparam logic [15:0] MSIP_OFF        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

    // Caller passes a word-aligned offset; byte lanes are not decoded.
    function automatic reg_sel_e decode_off(input logic [15:0] off);
        reg_sel_e sel;
        case (off)
            MSIP_OFF:        sel = REG_MSIP;
            MTIMECMP_LO_OFF: sel = REG_CMP_LO;
            MTIMECMP_HI_OFF: sel = REG_CMP_HI;
            MTIME_LO_OFF:    sel = REG_TIME_LO;
            MTIME_HI_OFF:    sel = REG_TIME_HI;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides clk into one-cycle mtime ticks, one every PRESCALE clocks.
// Tick is decoded from the counter flop; first tick PRESCALE clocks after reset.
// Free-running, no backpressure.
module clint_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt_q, pcnt_d;

    always_comb begin
        tick   = (pcnt_q == LAST);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_clint.sv
// Memory-mapped mtime/mtimecmp/msip block answering a 64 KiB window of the data port.
// Reads are 0-cycle combinational, writes commit on the edge; timer_irq lags compare by 1.
// Always ready: no stalls, every access in the window completes in its cycle.
module mmio_clint #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        hit,
    output logic        timer_irq,
    output logic        sw_irq
);

    import clint_pkg::*;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        timer_irq_q, timer_irq_d;
    logic        tick;
    logic        we;
    reg_sel_e    sel;
    logic        unused_byte_lane;

    assign unused_byte_lane = ^addr_in[1:0];

    clint_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        hit = (addr_in[31:16] == BASE_ADDR[31:16]);
        sel = hit ? decode_off({addr_in[15:2], 2'b00}) : REG_NONE;
        we  = mem_write & hit;

        mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        timer_irq_d = (mtime_q >= mtimecmp_q);

        // A software write to either mtime half replaces that cycle's increment.
        if (we) begin
            case (sel)
                REG_MSIP:    msip_d     = data_in[0];
                REG_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], data_in};
                REG_CMP_HI:  mtimecmp_d = {data_in, mtimecmp_q[31:0]};
                REG_TIME_LO: mtime_d    = {mtime_q[63:32], data_in};
                REG_TIME_HI: mtime_d    = {data_in, mtime_q[31:0]};
                default:     ;
            endcase
        end

        case (sel)
            REG_MSIP:    data_out = {31'd0, msip_q};
            REG_CMP_LO:  data_out = mtimecmp_q[31:0];
            REG_CMP_HI:  data_out = mtimecmp_q[63:32];
            REG_TIME_LO: data_out = mtime_q[31:0];
            REG_TIME_HI: data_out = mtime_q[63:32];
            default:     data_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RST;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    assign timer_irq = timer_irq_q;
    assign sw_irq    = msip_q;

endmodule

// File: tb/tb_mmio_clint.sv
// Directed plus random bench for mmio_clint at PRESCALE 1 and 4 sharing one bus.
// Expected values come from an arithmetic model of the register map and timer.
module tb_mmio_clint;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, data_in;
    logic        mem_write;
    logic [31:0] dout0, dout1;
    logic        hit0, hit1, tirq0, tirq1, sw0, sw1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .mem_write(mem_write),
        .data_out(dout0), .hit(hit0), .timer_irq(tirq0), .sw_irq(sw0)
    );

    mmio_clint #(.BASE_ADDR(32'h0200_0000), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in), .mem_write(mem_write),
        .data_out(dout1), .hit(hit1), .timer_irq(tirq1), .sw_irq(sw1)
    );

    // Reference state, one entry per instance.
    int          presc [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    bit          m_msip [2];
    int          m_pcnt [2];
    bit          m_tirq [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:16] == 16'h0200;
    endfunction

    function automatic logic [31:0] m_read(input int i, input logic [31:0] a);
        logic [15:0] off;
        off = {a[15:2], 2'b00};
        if (!m_hit(a)) return 32'd0;
        case (off)
            16'h0000: return {31'd0, m_msip[i]};
            16'h4000: return m_cmp[i][31:0];
            16'h4004: return m_cmp[i][63:32];
            16'hBFF8: return m_time[i][31:0];
            16'hBFFC: return m_time[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_time[i] = 64'd0;
            m_cmp[i]  = '1;
            m_msip[i] = 1'b0;
            m_pcnt[i] = 0;
            m_tirq[i] = 1'b0;
        end
    endtask

    // One clock: next state from the present inputs, committed after the edge.
    task automatic step();
        logic [63:0] nt [2];
        logic [63:0] nc [2];
        bit          nm [2];
        int          np [2];
        bit          ni [2];
        bit          tk, we;
        logic [15:0] off;
        we  = mem_write && m_hit(addr_in);
        off = {addr_in[15:2], 2'b00};
        for (int i = 0; i < 2; i++) begin
            tk    = (m_pcnt[i] == presc[i] - 1);
            np[i] = tk ? 0 : m_pcnt[i] + 1;
            ni[i] = (m_time[i] >= m_cmp[i]);
            nt[i] = m_time[i];
            nc[i] = m_cmp[i];
            nm[i] = m_msip[i];
            if (we && off == 16'hBFF8)      nt[i][31:0]  = data_in;
            else if (we && off == 16'hBFFC) nt[i][63:32] = data_in;
            else if (tk)                    nt[i]        = m_time[i] + 64'd1;
            if (we && off == 16'h4000) nc[i][31:0]  = data_in;
            if (we && off == 16'h4004) nc[i][63:32] = data_in;
            if (we && off == 16'h0000) nm[i]        = data_in[0];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_time[i] = nt[i];
            m_cmp[i]  = nc[i];
            m_msip[i] = nm[i];
            m_pcnt[i] = np[i];
            m_tirq[i] = ni[i];
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, "_hit0"},  hit0,  m_hit(addr_in));
        chk({tag, "_hit1"},  hit1,  m_hit(addr_in));
        chk({tag, "_dout0"}, dout0, m_read(0, addr_in));
        chk({tag, "_dout1"}, dout1, m_read(1, addr_in));
        chk({tag, "_tirq0"}, tirq0, m_tirq[0]);
        chk({tag, "_tirq1"}, tirq1, m_tirq[1]);
        chk({tag, "_sw0"},   sw0,   m_msip[0]);
        chk({tag, "_sw1"},   sw1,   m_msip[1]);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_in   = a;
        data_in   = d;
        mem_write = 1'b1;
        step();
        mem_write = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        addr_in   = a;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rand_addrs [8];
        logic [31:0] a, d;
        rand_addrs = '{32'h0200_0000, 32'h0200_4000, 32'h0200_4004, 32'h0200_BFF8,
                       32'h0200_BFFC, 32'h0200_0008, 32'h0300_BFF8, 32'h0200_7FF0};

        rst = 1'b0; addr_in = 32'h0200_BFF8; data_in = 32'd0; mem_write = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        chk("reset_mtime_lo", dout0, 32'd0);
        chk("reset_tirq", tirq0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        repeat (10) step();
        set_addr(32'h0200_BFF8);
        check_all("idle");
        chk("idle_mtime_p1", dout0, 32'd10);
        chk("idle_mtime_p4", dout1, 32'd2);
        chk("idle_sw", sw0, 1'b0);

        wr(32'h0200_0000, 32'h0000_0001);
        check_all("msip_set");
        chk("msip_set_sw", sw0, 1'b1);
        wr(32'h0200_0000, 32'hFFFF_FFFE);
        check_all("msip_clr");
        chk("msip_clr_sw", sw0, 1'b0);
        set_addr(32'h0200_0008);
        check_all("unmapped");
        chk("unmapped_rd", dout0, 32'd0);

        wr(32'h0200_BFF8, 32'hFFFF_FFFE);
        wr(32'h0200_BFFC, 32'h0000_0000);
        set_addr(32'h0100_0000);
        repeat (3) step();
        set_addr(32'h0200_BFF8);
        check_all("wrap_lo");
        chk("wrap_lo_p1", dout0, 32'd1);
        set_addr(32'h0200_BFFE);
        check_all("wrap_hi");
        chk("wrap_hi_p1", dout0, 32'd1);

        wr(32'h0200_BFF8, 32'h0000_1234);
        check_all("lo_over_tick");
        chk("lo_over_tick_p1", dout0, 32'h0000_1234);

        wr(32'h0200_4000, 32'd20);
        wr(32'h0200_4004, 32'd0);
        wr(32'h0200_BFFC, 32'd0);
        wr(32'h0200_BFF8, 32'd18);
        step();
        check_all("irq_n1");
        step();
        check_all("irq_n2");
        chk("irq_n2_p1", tirq0, 1'b0);
        step();
        check_all("irq_n3");
        chk("irq_n3_p1", tirq0, 1'b1);
        wr(32'h0200_4004, 32'd1);
        check_all("cmp_hi_m");
        step();
        check_all("cmp_hi_m1");
        chk("cmp_hi_clear", tirq0, 1'b0);

        addr_in = 32'h0300_BFF8; data_in = 32'hDEAD_BEEF; mem_write = 1'b1;
        check_all("miss");
        chk("miss_hit", hit0, 1'b0);
        chk("miss_dout", dout0, 32'd0);
        step();
        set_addr(32'h0200_BFF8);
        check_all("miss_after");

        repeat (2) step();
        #2 rst = 1'b0;
        #1 model_reset();
        chk("arst_mtime_p1", dout0, 32'd0);
        chk("arst_mtime_p4", dout1, 32'd0);
        chk("arst_tirq", tirq0, 1'b0);
        #1 rst = 1'b1;
        repeat (3) step();
        check_all("post_rst3");
        chk("post_rst3_p4", dout1, 32'd0);
        step();
        check_all("post_rst4");
        chk("post_rst4_p4", dout1, 32'd1);
        chk("post_rst4_p1", dout0, 32'd4);

        for (int n = 0; n < 400; n++) begin
            a = rand_addrs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else                           d = 32'($urandom_range(0, 40));
            addr_in   = a;
            data_in   = d;
            mem_write = ($urandom_range(0, 2) == 0);
            check_all($sformatf("rnd%0d", n));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
